wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and a long-latency execution unit (mul/div, MDU). MDU results are queued in a small FIFO and interleaved into idle writeback slots. A starvation counter forces an MDU slot by stalling writeback. The block sits between the writeback stage, the MDU result interface and the register file. It also exports a pending-rd mask for hazard detection.

---
 rtl/wb_port_arbiter_if.sv | 27 ++
 rtl/wb_port_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bundle of writeback, MDU result and register-file write-port signals.
// The slave modport is the arbiter; the master modport is its environment.
interface wb_port_arbiter_if;
   logic        wb_valid;
   logic        wb_reg_w;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        wb_stall;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [63:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [31:0] mdu_pending;

   modport master (
      output wb_valid, wb_reg_w, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
      input  wb_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, mdu_pending
   );

   modport slave (
      input  wb_valid, wb_reg_w, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
      output wb_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, mdu_pending
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. queued MDU results,
// with a starvation counter that forces an MDU slot by stalling writeback.
module wb_port_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              rst,
   wb_port_arbiter_if.slave bus
);
   localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned NREG = 32;

   logic [4:0]      fifo_rd   [FIFO_DEPTH];
   logic [63:0]     fifo_data [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
   logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
   logic [CNTW-1:0] count, count_nxt;
   logic [SW-1:0]   starve, starve_nxt;
   logic [CNTW-1:0] occ     [NREG];
   logic [CNTW-1:0] occ_nxt [NREG];
   logic [31:0]     pend_nxt;

   logic       preq, mreq, starved, gm, gp, push, pop;
   logic [4:0] head_rd;

   // Request / grant decode
   assign preq    = bus.wb_valid & bus.wb_reg_w & (bus.wb_rd != 5'd0);
   assign mreq    = (count != '0);
   assign starved = (starve >= SW'(STARVE_LIMIT));
   assign gm      = mreq & (~preq | starved);
   assign gp      = preq & ~gm;
   assign head_rd = fifo_rd[rd_ptr];

   assign bus.wb_stall  = preq & gm;
   assign bus.mdu_ready = (count < CNTW'(FIFO_DEPTH));

   // rd=0 results complete the handshake but are never stored
   assign push = bus.mdu_valid & bus.mdu_ready & (bus.mdu_rd != 5'd0);
   assign pop  = gm;

   // Next-state: pointers, occupancy, per-register occurrence counts, starvation
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      count_nxt  = count;
      starve_nxt = starve;
      occ_nxt    = occ;
      pend_nxt   = '0;

      if (push) begin
         wr_ptr_nxt = wr_ptr + AW'(1);
         occ_nxt[bus.mdu_rd] = occ_nxt[bus.mdu_rd] + CNTW'(1);
      end
      if (pop) begin
         rd_ptr_nxt = rd_ptr + AW'(1);
         occ_nxt[head_rd] = occ_nxt[head_rd] - CNTW'(1);
      end

      case ({push, pop})
         2'b10:   count_nxt = count + CNTW'(1);
         2'b01:   count_nxt = count - CNTW'(1);
         default: count_nxt = count;
      endcase

      if (gm || !mreq) begin
         starve_nxt = '0;
      end else if (gp && !starved) begin
         starve_nxt = starve + SW'(1);
      end

      for (int i = 0; i < int'(NREG); i++) begin
         pend_nxt[i] = (occ_nxt[i] != '0);
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         starve          <= '0;
         bus.rf_we       <= 1'b0;
         bus.rf_waddr    <= 5'd0;
         bus.rf_wdata    <= 64'd0;
         bus.mdu_pending <= 32'd0;
         for (int i = 0; i < int'(NREG); i++) begin
            occ[i] <= '0;
         end
      end else begin
         rd_ptr          <= rd_ptr_nxt;
         wr_ptr          <= wr_ptr_nxt;
         count           <= count_nxt;
         starve          <= starve_nxt;
         occ             <= occ_nxt;
         bus.mdu_pending <= pend_nxt;
         if (gp) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.wb_rd;
            bus.rf_wdata <= bus.wb_data;
         end else if (gm) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= head_rd;
            bus.rf_wdata <= fifo_data[rd_ptr];
         end else begin
            bus.rf_we    <= 1'b0;
         end
      end
   end

   // Queue storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= bus.mdu_rd;
         fifo_data[wr_ptr] <= bus.mdu_data;
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   wb_port_arbiter_if bus ();

   wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_set(input logic v, input logic w, input logic [4:0] rd, input logic [63:0] d);
      bus.wb_valid = v;
      bus.wb_reg_w = w;
      bus.wb_rd    = rd;
      bus.wb_data  = d;
   endtask

   task automatic mdu_set(input logic v, input logic [4:0] rd, input logic [63:0] d);
      bus.mdu_valid = v;
      bus.mdu_rd    = rd;
      bus.mdu_data  = d;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      wb_set(1'b0, 1'b0, 5'd0, 64'd0);
      mdu_set(1'b0, 5'd0, 64'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
      chk("reset_waddr", 64'(bus.rf_waddr), 64'd0);
      chk("reset_wdata", bus.rf_wdata, 64'd0);
      chk("reset_pending", 64'(bus.mdu_pending), 64'd0);
      chk("reset_ready", 64'(bus.mdu_ready), 64'd1);
      chk("reset_stall", 64'(bus.wb_stall), 64'd0);

      // Idle pipeline, single MDU push rd=5
      mdu_set(1'b1, 5'd5, 64'h1234);
      #1;
      chk("push5_ready", 64'(bus.mdu_ready), 64'd1);
      tick();
      mdu_set(1'b0, 5'd0, 64'd0);
      #1;
      chk("push5_c1_pending", 64'(bus.mdu_pending), 64'h20);
      chk("push5_c1_rf_we", 64'(bus.rf_we), 64'd0);
      tick();
      chk("push5_c2_rf_we", 64'(bus.rf_we), 64'd1);
      chk("push5_c2_waddr", 64'(bus.rf_waddr), 64'd5);
      chk("push5_c2_wdata", bus.rf_wdata, 64'h1234);
      chk("push5_c2_pending", 64'(bus.mdu_pending), 64'd0);
      tick();
      chk("push5_c3_rf_we", 64'(bus.rf_we), 64'd0);
      chk("push5_c3_waddr_hold", 64'(bus.rf_waddr), 64'd5);

      // Starvation: continuous preq rd=3 with one queued rd=7
      wb_set(1'b1, 1'b1, 5'd3, 64'h33);
      mdu_set(1'b1, 5'd7, 64'h77);
      #1;
      chk("starve_c0_stall", 64'(bus.wb_stall), 64'd0);
      tick();
      mdu_set(1'b0, 5'd0, 64'd0);
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("starve_c%0d_stall", c), 64'(bus.wb_stall), 64'd0);
         chk($sformatf("starve_c%0d_pending", c), 64'(bus.mdu_pending), 64'h80);
         tick();
         chk($sformatf("starve_c%0d_waddr", c), 64'(bus.rf_waddr), 64'd3);
      end
      #1;
      chk("starve_c5_stall", 64'(bus.wb_stall), 64'd1);
      tick();
      chk("starve_c5_waddr", 64'(bus.rf_waddr), 64'd7);
      chk("starve_c5_wdata", bus.rf_wdata, 64'h77);
      chk("starve_c6_pending", 64'(bus.mdu_pending), 64'd0);
      #1;
      chk("starve_c6_stall", 64'(bus.wb_stall), 64'd0);
      tick();
      chk("starve_c6_waddr", 64'(bus.rf_waddr), 64'd3);
      chk("starve_c6_wdata", bus.rf_wdata, 64'h33);

      // Fill FIFO with two rd=9 entries while the pipeline holds the port
      mdu_set(1'b1, 5'd9, 64'h91);
      tick();
      mdu_set(1'b1, 5'd9, 64'h92);
      #1;
      chk("full_second_ready", 64'(bus.mdu_ready), 64'd1);
      tick();
      mdu_set(1'b1, 5'd10, 64'hA0);
      #1;
      chk("full_third_ready", 64'(bus.mdu_ready), 64'd0);
      chk("full_pending", 64'(bus.mdu_pending), 64'h200);
      tick();
      wb_set(1'b0, 1'b0, 5'd0, 64'd0);
      mdu_set(1'b0, 5'd0, 64'd0);
      tick();
      chk("full_pop1_waddr", 64'(bus.rf_waddr), 64'd9);
      chk("full_pop1_wdata", bus.rf_wdata, 64'h91);
      chk("full_pop1_pending", 64'(bus.mdu_pending), 64'h200);
      chk("full_pop1_ready", 64'(bus.mdu_ready), 64'd1);
      tick();
      chk("full_pop2_wdata", bus.rf_wdata, 64'h92);
      chk("full_pop2_pending", 64'(bus.mdu_pending), 64'd0);
      tick();
      chk("full_drained_rf_we", 64'(bus.rf_we), 64'd0);

      // Non-writing writeback lets a queued MDU entry take the port
      wb_set(1'b1, 1'b1, 5'd4, 64'h44);
      mdu_set(1'b1, 5'd12, 64'hC0);
      tick();
      mdu_set(1'b0, 5'd0, 64'd0);
      wb_set(1'b1, 1'b1, 5'd0, 64'hEE);
      #1;
      chk("rd0_stall", 64'(bus.wb_stall), 64'd0);
      tick();
      chk("rd0_mdu_waddr", 64'(bus.rf_waddr), 64'd12);
      chk("rd0_mdu_wdata", bus.rf_wdata, 64'hC0);
      wb_set(1'b1, 1'b0, 5'd4, 64'hEF);
      #1;
      chk("nowr_stall", 64'(bus.wb_stall), 64'd0);
      tick();
      chk("nowr_rf_we", 64'(bus.rf_we), 64'd0);

      // MDU push with rd=0: accepted, not stored
      wb_set(1'b0, 1'b0, 5'd0, 64'd0);
      mdu_set(1'b1, 5'd0, 64'hDEAD);
      #1;
      chk("mdu_rd0_ready", 64'(bus.mdu_ready), 64'd1);
      tick();
      mdu_set(1'b0, 5'd0, 64'd0);
      chk("mdu_rd0_pending", 64'(bus.mdu_pending), 64'd0);
      tick();
      chk("mdu_rd0_rf_we", 64'(bus.rf_we), 64'd0);

      // Same-cycle push and pop of the same rd keeps pending set
      wb_set(1'b1, 1'b1, 5'd2, 64'h22);
      mdu_set(1'b1, 5'd6, 64'h60);
      tick();
      wb_set(1'b0, 1'b0, 5'd0, 64'd0);
      mdu_set(1'b1, 5'd6, 64'h61);
      tick();
      mdu_set(1'b0, 5'd0, 64'd0);
      chk("pushpop_pending", 64'(bus.mdu_pending), 64'h40);
      chk("pushpop_wdata", bus.rf_wdata, 64'h60);
      tick();
      chk("pushpop2_wdata", bus.rf_wdata, 64'h61);
      chk("pushpop2_pending", 64'(bus.mdu_pending), 64'd0);

      // Reset while two entries are queued
      wb_set(1'b1, 1'b1, 5'd3, 64'h33);
      mdu_set(1'b1, 5'd11, 64'hB1);
      tick();
      mdu_set(1'b1, 5'd13, 64'hD1);
      tick();
      mdu_set(1'b0, 5'd0, 64'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("midrst_pending", 64'(bus.mdu_pending), 64'd0);
      chk("midrst_ready", 64'(bus.mdu_ready), 64'd1);
      chk("midrst_stall", 64'(bus.wb_stall), 64'd0);
      tick();
      rst = 1'b1;
      wb_set(1'b0, 1'b0, 5'd0, 64'd0);
      tick();
      chk("postrst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("postrst_pending", 64'(bus.mdu_pending), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
